// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack-pointer request sequencer:
// request opcodes, the FSM state type and the active-low strobe bundle
// driven toward the 16-bit stack pointer.
package stack_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_DEC,
    ST_PUSH_WR,
    ST_POP_RD,
    ST_POP_INC,
    ST_LOAD,
    ST_REJECT
  } state_t;

  // All members are active low; '1 means the pointer is left alone.
  typedef struct packed {
    logic outn;
    logic loadn;
    logic cupn;
    logic cdownn;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '{outn: 1'b1, loadn: 1'b1, cupn: 1'b1, cdownn: 1'b1};

  // Exactly one strobe (or none) per state, so at most one is ever low.
  function automatic strobe_t strobe_for(state_t s);
    strobe_t st;
    st = STROBE_NONE;
    case (s)
      ST_PUSH_DEC: st.cdownn = 1'b0;
      ST_PUSH_WR:  st.outn   = 1'b0;
      ST_POP_RD:   st.outn   = 1'b0;
      ST_POP_INC:  st.cupn   = 1'b0;
      ST_LOAD:     st.loadn  = 1'b0;
      default:     st = STROBE_NONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Request/strobe bundle between the instruction decoder (master) and the
// stack sequencer (slave).
//   req_valid/req_op/req_ready : one-at-a-time request handshake
//   sp_outn/loadn/cupn/cdownn  : active-low stack pointer strobes
//   mem_wr/mem_rd              : memory strobes at the pointer address
//   done/err                   : completion pulse, err marks a rejection
//   overflow/underflow/depth   : sticky status and live entry count
interface stack_sequencer_if #(
  parameter int DEPTH_W = 9
);
  logic               req_valid;
  logic [1:0]         req_op;
  logic               req_ready;
  logic               sp_outn;
  logic               sp_loadn;
  logic               sp_cupn;
  logic               sp_cdownn;
  logic               mem_wr;
  logic               mem_rd;
  logic               done;
  logic               err;
  logic               overflow;
  logic               underflow;
  logic [DEPTH_W-1:0] depth;

  modport master (
    output req_valid, req_op,
    input  req_ready, sp_outn, sp_loadn, sp_cupn, sp_cdownn,
           mem_wr, mem_rd, done, err, overflow, underflow, depth
  );

  modport slave (
    input  req_valid, req_op,
    output req_ready, sp_outn, sp_loadn, sp_cupn, sp_cdownn,
           mem_wr, mem_rd, done, err, overflow, underflow, depth
  );
endinterface

// File: rtl/stack_sequencer_depth_tracker.sv
// Live-entry counter for the stack plus sticky overflow/underflow flags.
// Ports:
//   clk, reset        : clock, async active-high reset
//   inc, dec, clr     : count change requests (clr wins)
//   set_ovf, set_unf  : set the sticky flags (clr clears them)
//   depth             : current live entries
//   full, empty       : depth == MAX_DEPTH / depth == 0
//   overflow/underflow: sticky flags
module stack_depth_tracker #(
  parameter int MAX_DEPTH = 256,
  parameter int DEPTH_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  input  logic               set_ovf,
  input  logic               set_unf,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic               underflow
);

  // The FSM never requests inc at full or dec at empty, so no saturation
  // logic is needed here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr)      depth <= '0;
      else if (inc) depth <= depth + DEPTH_W'(1);
      else if (dec) depth <= depth - DEPTH_W'(1);

      if (clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (set_ovf) overflow  <= 1'b1;
        if (set_unf) underflow <= 1'b1;
      end
    end
  end

  assign full  = (depth == DEPTH_W'(MAX_DEPTH));
  assign empty = (depth == '0);

endmodule

// File: rtl/stack_sequencer.sv
// Stack request sequencer: accepts PUSH/POP/LOAD_SP requests and plays
// them out as registered stack-pointer and memory strobes.
// Ports:
//   clk, reset : clock, async active-high reset
//   bus        : slave side of stack_sequencer_if (handshake, strobes,
//                done/err, sticky flags, depth)
//
// state       | meaning
// ------------+------------------------------------------------
// ST_IDLE     | ready for a request
// ST_PUSH_DEC | pre-decrement pointer (sp_cdownn low)
// ST_PUSH_WR  | pointer drives address, memory write, done
// ST_POP_RD   | pointer drives address, memory read
// ST_POP_INC  | post-increment pointer (sp_cupn low), done
// ST_LOAD     | pointer loads from bus (sp_loadn low), done
// ST_REJECT   | over/underflowing request dropped, done + err
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int MAX_DEPTH = 256,
  parameter int DEPTH_W   = 9
) (
  input  logic             clk,
  input  logic             reset,
  stack_sequencer_if.slave bus
);

  state_t  state, next_state;
  strobe_t strobe_d, strobe_q;
  logic    wr_d, rd_d, done_d, err_d;
  logic    wr_q, rd_q, done_q, err_q, ready_q;
  logic    accept;
  logic    full, empty;
  logic [DEPTH_W-1:0] depth;

  assign accept = (state == ST_IDLE) && bus.req_valid;

  // State register plus output registers; outputs are decoded from
  // next_state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      strobe_q <= STROBE_NONE;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state    <= next_state;
      strobe_q <= strobe_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= (next_state == ST_IDLE);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_PUSH: next_state = full  ? ST_REJECT : ST_PUSH_DEC;
            OP_POP:  next_state = empty ? ST_REJECT : ST_POP_RD;
            OP_LOAD: next_state = ST_LOAD;
            OP_NOP:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
          endcase
        end
      end
      ST_PUSH_DEC: next_state = ST_PUSH_WR;
      ST_POP_RD:   next_state = ST_POP_INC;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    strobe_d = strobe_for(next_state);
    wr_d     = (next_state == ST_PUSH_WR);
    rd_d     = (next_state == ST_POP_RD);
    done_d   = (next_state == ST_PUSH_WR) || (next_state == ST_POP_INC) ||
               (next_state == ST_LOAD)    || (next_state == ST_REJECT);
    err_d    = (next_state == ST_REJECT);
  end

  // Depth moves on the edge leaving the first cycle of a PUSH/POP, so the
  // new count is visible in the cycle that carries done.
  stack_depth_tracker #(
    .MAX_DEPTH (MAX_DEPTH),
    .DEPTH_W   (DEPTH_W)
  ) u_depth (
    .clk       (clk),
    .reset     (reset),
    .inc       (state == ST_PUSH_DEC),
    .dec       (state == ST_POP_RD),
    .clr       (accept && (bus.req_op == OP_LOAD)),
    .set_ovf   (accept && (bus.req_op == OP_PUSH) && full),
    .set_unf   (accept && (bus.req_op == OP_POP) && empty),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .overflow  (bus.overflow),
    .underflow (bus.underflow)
  );

  assign bus.req_ready = ready_q;
  assign bus.sp_outn   = strobe_q.outn;
  assign bus.sp_loadn  = strobe_q.loadn;
  assign bus.sp_cupn   = strobe_q.cupn;
  assign bus.sp_cdownn = strobe_q.cdownn;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_rd    = rd_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.depth     = depth;

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer. Each accepted request is expanded
// into the expected per-cycle output trace, which is compared cycle by
// cycle at the falling edge.
module tb_stack_sequencer;

  localparam int MAXD = 4;
  localparam int DW   = 9;
  localparam int NOP = 0, PUSH = 1, POP = 2, LOAD = 3;

  typedef struct {
    logic [3:0]    sp;   // {outn, loadn, cupn, cdownn}
    logic          wr, rd, done, err, ready;
    logic [DW-1:0] depth;
    logic          ovf, unf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t exp_q[$];
  int   dir_q[$];
  int   m_depth;
  logic m_ovf, m_unf;

  stack_sequencer_if #(.DEPTH_W(DW)) bus ();

  stack_sequencer #(.MAX_DEPTH(MAXD), .DEPTH_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(logic [3:0] sp, logic wr, logic rd, logic done, logic err,
                              int depth, logic ovf, logic unf);
    exp_t e;
    e.sp = sp; e.wr = wr; e.rd = rd; e.done = done; e.err = err; e.ready = 1'b0;
    e.depth = DW'(depth); e.ovf = ovf; e.unf = unf;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = mk(4'b1111, 0, 0, 0, 0, m_depth, m_ovf, m_unf);
    e.ready = 1'b1;
    return e;
  endfunction

  // Expected trace of one accepted request, starting the cycle after acceptance.
  task automatic accept_model(input int op);
    case (op)
      PUSH: begin
        if (m_depth == MAXD) begin
          m_ovf = 1'b1;
          exp_q.push_back(mk(4'b1111, 0, 0, 1, 1, m_depth, m_ovf, m_unf));
        end else begin
          exp_q.push_back(mk(4'b1110, 0, 0, 0, 0, m_depth, m_ovf, m_unf));
          m_depth++;
          exp_q.push_back(mk(4'b0111, 1, 0, 1, 0, m_depth, m_ovf, m_unf));
        end
      end
      POP: begin
        if (m_depth == 0) begin
          m_unf = 1'b1;
          exp_q.push_back(mk(4'b1111, 0, 0, 1, 1, m_depth, m_ovf, m_unf));
        end else begin
          exp_q.push_back(mk(4'b0111, 0, 1, 0, 0, m_depth, m_ovf, m_unf));
          m_depth--;
          exp_q.push_back(mk(4'b1101, 0, 0, 1, 0, m_depth, m_ovf, m_unf));
        end
      end
      LOAD: begin
        m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        exp_q.push_back(mk(4'b1011, 0, 0, 1, 0, 0, 0, 0));
      end
      default: ;
    endcase
  endtask

  // One cycle: compare outputs against the model, then drive the next request.
  task automatic step();
    exp_t       e;
    logic [3:0] sp;
    int         op;
    logic       v;
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = idle_exp();
    sp = {bus.sp_outn, bus.sp_loadn, bus.sp_cupn, bus.sp_cdownn};
    check_eq("sp_strobes", 32'(sp), 32'(e.sp));
    check_eq("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
    check_eq("mem_rd", 32'(bus.mem_rd), 32'(e.rd));
    check_eq("done", 32'(bus.done), 32'(e.done));
    check_eq("err", 32'(bus.err), 32'(e.err));
    check_eq("req_ready", 32'(bus.req_ready), 32'(e.ready));
    check_eq("depth", 32'(bus.depth), 32'(e.depth));
    check_eq("overflow", 32'(bus.overflow), 32'(e.ovf));
    check_eq("underflow", 32'(bus.underflow), 32'(e.unf));
    check_eq("one_strobe_max", 32'($countones(~sp) <= 1), 32'(1));
    check_eq("memstrobe_with_outn", 32'((bus.mem_wr | bus.mem_rd) & bus.sp_outn), 32'(0));

    if (e.ready) begin
      if (dir_q.size() > 0) begin
        op = dir_q.pop_front();
        v  = 1'b1;
      end else begin
        op = int'($urandom_range(0, 3));
        v  = ($urandom_range(0, 3) != 0);
      end
      bus.req_valid = v;
      bus.req_op    = op[1:0];
      if (v) accept_model(op);
    end else begin
      // Busy: anything on the request lines must be ignored.
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_op    = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;

    #12;
    check_eq("rst_strobes", 32'({bus.sp_outn, bus.sp_loadn, bus.sp_cupn, bus.sp_cdownn}), 32'hF);
    check_eq("rst_mem", 32'({bus.mem_wr, bus.mem_rd}), 32'(0));
    check_eq("rst_done_err", 32'({bus.done, bus.err}), 32'(0));
    check_eq("rst_flags", 32'({bus.overflow, bus.underflow}), 32'(0));
    check_eq("rst_depth", 32'(bus.depth), 32'(0));

    @(negedge clk);
    reset = 1'b0;

    // Directed walk: basic push/pop, underflow then LOAD_SP, fill to
    // MAX_DEPTH plus one rejected push, pop with sticky overflow, NOP.
    dir_q = '{PUSH, PUSH, POP, POP, POP, LOAD,
              PUSH, PUSH, PUSH, PUSH, PUSH, POP, NOP, LOAD};
    repeat (60) step();

    repeat (500) step();

    // Reset while in PUSH_DEC after two completed pushes.
    dir_q = '{LOAD, PUSH, PUSH, PUSH};
    guard = 0;
    while (!(dir_q.size() == 0 && exp_q.size() == 2) && guard < 100) begin
      step();
      guard++;
    end
    check_eq("reset_setup_reached", 32'(exp_q.size()), 32'(2));
    @(posedge clk);
    #2;
    check_eq("pre_reset_cdownn", 32'(bus.sp_cdownn), 32'(0));
    check_eq("pre_reset_depth", 32'(bus.depth), 32'(2));
    reset = 1'b1;
    #1;
    check_eq("midrst_cdownn", 32'(bus.sp_cdownn), 32'(1));
    check_eq("midrst_depth", 32'(bus.depth), 32'(0));
    check_eq("midrst_done", 32'(bus.done), 32'(0));
    check_eq("midrst_mem_wr", 32'(bus.mem_wr), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    exp_q.delete();
    m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    dir_q = '{PUSH};
    repeat (100) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
